spi_link_pair: RTL and testbench

//  Self-contained SPI mode-0 link: one master engine and one slave endpoint on a shared system clock.

---
 rtl/spi_link_pair_if.sv | 27 ++
 rtl/spi_link_pair.sv | 181 ++++++++++++++++++
 tb/tb_spi_link_pair.sv | 139 +++++++++++++
 3 files changed

// File: rtl/spi_link_pair_if.sv
// Bundle of host-side request/response signals and the exported SPI pins for spi_link_pair.
// The slave modport is the link itself; the master modport is whatever host drives it.
interface spi_link_pair_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] mosi_data;
  logic [DATA_WIDTH-1:0] miso_data;
  logic                  done;
  logic [DATA_WIDTH-1:0] slave_tx_data;
  logic [DATA_WIDTH-1:0] slave_rx_data;
  logic                  slave_rx_valid;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic                  cs_n;

  modport slave (
    input  start, mosi_data, slave_tx_data,
    output miso_data, done, slave_rx_data, slave_rx_valid, sclk, mosi, miso, cs_n
  );

  modport master (
    output start, mosi_data, slave_tx_data,
    input  miso_data, done, slave_rx_data, slave_rx_valid, sclk, mosi, miso, cs_n
  );
endinterface

// File: rtl/spi_link_pair.sv
// SPI mode-0 master engine plus slave endpoint on one clock; full-duplex DATA_WIDTH-bit words, MSB first.
// The slave follows the master's registered sclk/cs_n, so it always reacts one clk after each SPI edge.
module spi_link_pair #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic           clk,
  input  logic           rst,
  spi_link_pair_if.slave bus
);
  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam int DCW = $clog2(CLK_DIV + 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t                state_q, state_d;
  logic [DCW-1:0]        div_q, div_d;
  logic [BCW-1:0]        bit_q, bit_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] miso_data_q, miso_data_d;
  // Holds only the bits still to be sent; the MSB goes straight to mosi at start.
  logic [DATA_WIDTH-2:0] mtx_q, mtx_d;
  logic [DATA_WIDTH-1:0] mrx_q, mrx_d;
  logic                  tick;
  logic                  miso_w;

  logic                  cs_prev_q;
  logic                  sclk_prev_q;
  logic                  cs_fall;
  logic                  s_rise;
  logic                  s_fall;
  logic [DATA_WIDTH-1:0] stx_q;
  logic [DATA_WIDTH-2:0] srx_q;
  logic [BCW-1:0]        sbit_q;
  logic [DATA_WIDTH-1:0] srx_data_q;
  logic                  srx_vld_q;

  assign tick = (div_q == DCW'(CLK_DIV));

  always_comb begin
    state_d     = state_q;
    div_d       = tick ? DCW'(1) : div_q + DCW'(1);
    bit_d       = bit_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    done_d      = 1'b0;
    miso_data_d = miso_data_q;
    mtx_d       = mtx_q;
    mrx_d       = mrx_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mtx_d   = bus.mosi_data[DATA_WIDTH-2:0];
          mosi_d  = bus.mosi_data[DATA_WIDTH-1];
          cs_n_d  = 1'b0;
          bit_d   = '0;
          div_d   = DCW'(1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          mrx_d   = {mrx_q[DATA_WIDTH-2:0], miso_w};
          state_d = XFER;
        end
      end
      XFER: begin
        if (tick) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q == BCW'(DATA_WIDTH - 1)) begin
              state_d = HOLD;
            end else begin
              bit_d  = bit_q + BCW'(1);
              mosi_d = mtx_q[DATA_WIDTH-2];
              mtx_d  = (DATA_WIDTH-1)'({mtx_q, 1'b0});
            end
          end else begin
            sclk_d = 1'b1;
            mrx_d  = {mrx_q[DATA_WIDTH-2:0], miso_w};
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_n_d      = 1'b1;
          done_d      = 1'b1;
          miso_data_d = mrx_q;
          mosi_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      div_q       <= DCW'(1);
      bit_q       <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      done_q      <= 1'b0;
      miso_data_q <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      done_q      <= done_d;
      miso_data_q <= miso_data_d;
    end
  end

  always_ff @(posedge clk) begin
    mtx_q <= mtx_d;
    mrx_q <= mrx_d;
  end

  // Slave edge detection against the master's registered pins.
  assign cs_fall = cs_prev_q & ~cs_n_q;
  assign s_rise  = ~sclk_prev_q & sclk_q & ~cs_n_q;
  assign s_fall  = sclk_prev_q & ~sclk_q & ~cs_n_q;

  // miso shows the new bit during the detection cycle itself, so even CLK_DIV=1 samples a settled bit.
  always_comb begin
    miso_w = stx_q[DATA_WIDTH-1];
    if (cs_n_q)       miso_w = 1'b0;
    else if (cs_fall) miso_w = bus.slave_tx_data[DATA_WIDTH-1];
    else if (s_fall)  miso_w = stx_q[DATA_WIDTH-2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      sbit_q      <= '0;
      srx_data_q  <= '0;
      srx_vld_q   <= 1'b0;
    end else begin
      cs_prev_q   <= cs_n_q;
      sclk_prev_q <= sclk_q;
      srx_vld_q   <= 1'b0;
      if (cs_n_q) begin
        sbit_q <= '0;
      end else if (s_rise) begin
        if (sbit_q == BCW'(DATA_WIDTH - 1)) begin
          sbit_q     <= '0;
          srx_data_q <= {srx_q, mosi_q};
          srx_vld_q  <= 1'b1;
        end else begin
          sbit_q <= sbit_q + BCW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cs_fall)     stx_q <= bus.slave_tx_data;
    else if (s_fall) stx_q <= {stx_q[DATA_WIDTH-2:0], 1'b0};
    if (s_rise)      srx_q <= (DATA_WIDTH-1)'({srx_q, mosi_q});
  end

  assign bus.miso_data      = miso_data_q;
  assign bus.done           = done_q;
  assign bus.slave_rx_data  = srx_data_q;
  assign bus.slave_rx_valid = srx_vld_q;
  assign bus.sclk           = sclk_q;
  assign bus.mosi           = mosi_q;
  assign bus.miso           = miso_w;
  assign bus.cs_n           = cs_n_q;
endmodule

// File: tb/tb_spi_link_pair.sv
// Directed bench for spi_link_pair (DATA_WIDTH=8, CLK_DIV=4): hand-computed words, latency and pin activity.
module tb_spi_link_pair;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  spi_link_pair_if #(.DATA_WIDTH(8)) bus ();

  spi_link_pair #(.DATA_WIDTH(8), .CLK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge (E0).
  task automatic xfer(input string tag, input logic [7:0] md, input logic [7:0] sd,
                      input logic [7:0] exp_m, input logic [7:0] exp_s, input int poke);
    int   lat;
    int   rises;
    int   cslow;
    int   vlds;
    logic prev_sclk;
    lat       = -1;
    rises     = 0;
    cslow     = 0;
    vlds      = 0;
    prev_sclk = bus.sclk;
    bus.mosi_data     = md;
    bus.slave_tx_data = sd;
    bus.start         = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (poke != 0 && n == poke) begin
        bus.start     = 1'b1;
        bus.mosi_data = 8'hE7;
      end else if (poke != 0 && n == poke + 1) begin
        bus.start     = 1'b0;
        bus.mosi_data = md;
      end
      if (bus.sclk && !prev_sclk) rises++;
      prev_sclk = bus.sclk;
      if (bus.slave_rx_valid) vlds++;
      if (bus.done) begin
        lat = n - 1;
        break;
      end
      if (!bus.cs_n) cslow++;
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, 68);
    check({tag, "_miso_data"}, bus.miso_data, exp_m);
    check({tag, "_slave_rx"}, bus.slave_rx_data, exp_s);
    check({tag, "_rises"}, rises, 8);
    check({tag, "_cs_low"}, cslow, 68);
    check({tag, "_rx_valid"}, vlds, 1);
    check({tag, "_cs_high_at_done"}, bus.cs_n, 1'b1);
  endtask

  initial begin
    int stray;
    total             = 0;
    bad               = 0;
    rst               = 1'b0;
    bus.start         = 1'b0;
    bus.mosi_data     = '0;
    bus.slave_tx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", bus.cs_n, 1'b1);
    check("rst_sclk", bus.sclk, 1'b0);
    check("rst_mosi_miso", {bus.mosi, bus.miso}, 2'b00);
    check("rst_done_vld", {bus.done, bus.slave_rx_valid}, 2'b00);
    check("rst_words", {bus.miso_data, bus.slave_rx_data}, 16'h0000);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    xfer("t1", 8'h55, 8'h5A, 8'h5A, 8'h55, 0);
    @(negedge clk);
    check("t1_done_single", bus.done, 1'b0);
    repeat (3) @(negedge clk);
    xfer("t2", 8'h33, 8'hAA, 8'hAA, 8'h33, 0);
    repeat (2) @(negedge clk);
    xfer("t3a", 8'h00, 8'h00, 8'h00, 8'h00, 0);
    repeat (2) @(negedge clk);
    xfer("t3b", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
    @(negedge clk);
    xfer("t4a", 8'h22, 8'h11, 8'h11, 8'h22, 0);
    xfer("t4b", 8'h88, 8'h44, 8'h44, 8'h88, 0);
    @(negedge clk);
    xfer("t5", 8'h96, 8'h69, 8'h69, 8'h96, 30);
    @(negedge clk);
    check("t5_done_single", bus.done, 1'b0);
    check("t5_idle_cs", bus.cs_n, 1'b1);

    // Abort around bit 4 (fifth rise lands at E0+36).
    repeat (2) @(negedge clk);
    bus.mosi_data     = 8'hA5;
    bus.slave_tx_data = 8'h5A;
    bus.start         = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (38) @(negedge clk);
    check("t6_cs_active_before", bus.cs_n, 1'b0);
    rst = 1'b0;
    #1;
    check("t6_cs_n", bus.cs_n, 1'b1);
    check("t6_sclk", bus.sclk, 1'b0);
    check("t6_mosi_miso", {bus.mosi, bus.miso}, 2'b00);
    check("t6_done_vld", {bus.done, bus.slave_rx_valid}, 2'b00);
    check("t6_words", {bus.miso_data, bus.slave_rx_data}, 16'h0000);
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    stray = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (bus.done || bus.slave_rx_valid || !bus.cs_n) stray++;
    end
    check("t6_no_activity", stray, 0);
    @(negedge clk);
    xfer("t6r", 8'hC3, 8'h3C, 8'h3C, 8'hC3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
